// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle controller for the 8-bit MIPS datapath.
// Sequences byte-wide fetch, decode and execute of lb/sb/R-type/beq/j/addi.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14,
    UNUSED  = 4'd15
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     cur_state;
  state_t     next_state;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= FETCH1;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = FETCH1;
    case (cur_state)
      FETCH1: next_state = FETCH2;
      FETCH2: next_state = FETCH3;
      FETCH3: next_state = FETCH4;
      FETCH4: next_state = DECODE;
      DECODE: begin
        // Unrecognised opcodes fall back to fetch, acting as a no-op
        case (op)
          OP_LB:    next_state = MEMADR;
          OP_SB:    next_state = MEMADR;
          OP_RTYPE: next_state = RTYPEEX;
          OP_BEQ:   next_state = BEQEX;
          OP_J:     next_state = JEX;
          OP_ADDI:  next_state = ADDIEX;
          default:  next_state = FETCH1;
        endcase
      end
      MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    next_state = LBWR;
      LBWR:    next_state = FETCH1;
      SBWR:    next_state = FETCH1;
      RTYPEEX: next_state = RTYPEWR;
      RTYPEWR: next_state = FETCH1;
      BEQEX:   next_state = FETCH1;
      JEX:     next_state = FETCH1;
      ADDIEX:  next_state = ADDIWR;
      ADDIWR:  next_state = FETCH1;
      default: next_state = FETCH1;
    endcase
  end

  always_comb begin
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsource = 2'b00;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 4'b0000;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur_state)
      FETCH1: begin
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        irwrite = 4'b0001;
      end
      FETCH2: begin
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        irwrite = 4'b0010;
      end
      FETCH3: begin
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        irwrite = 4'b0100;
      end
      FETCH4: begin
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        irwrite = 4'b1000;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      LBRD: iord = 1'b1;
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        aluop    = 2'b10;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        branch   = 1'b1;
        pcsource = 2'b01;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
  end

  // aluop 10 hands the choice to funct; unknown functs default to add
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table-driven instruction
// vectors, an abort-by-reset sequence, and random instructions vs a model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic [3:0] irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alucontrol (alucontrol),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsource   (pcsource),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .state      (state)
  );

  typedef struct packed {
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [3:0] state;
  } out_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [1:0]  zmode;
    int          lat;
    logic [31:0] trace;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic out_t actual();
    out_t a;
    a.alucontrol = alucontrol;
    a.alusrca    = alusrca;
    a.alusrcb    = alusrcb;
    a.pcsource   = pcsource;
    a.pcen       = pcen;
    a.iord       = iord;
    a.memwrite   = memwrite;
    a.irwrite    = irwrite;
    a.regwrite   = regwrite;
    a.regdst     = regdst;
    a.memtoreg   = memtoreg;
    a.state      = state;
    return a;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b001000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
      default:   return 5;
    endcase
  endfunction

  // Expected outputs at cycle k (0-based) of an instruction with opcode o
  function automatic out_t expect_step(input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input int k);
    out_t e;
    e = '0;
    e.alucontrol = 3'b010;
    if (k < 4) begin
      e.state   = 4'(k);
      e.alusrcb = 2'b01;
      e.pcen    = 1'b1;
      e.irwrite = 4'(1 << k);
    end else if (k == 4) begin
      e.state   = 4'd4;
      e.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100000, 6'b101000: begin
          if (k == 5) begin
            e.state = 4'd5; e.alusrca = 1'b1; e.alusrcb = 2'b10;
          end else if (o == 6'b100000 && k == 6) begin
            e.state = 4'd6; e.iord = 1'b1;
          end else if (o == 6'b100000) begin
            e.state = 4'd7; e.regwrite = 1'b1; e.memtoreg = 1'b1;
          end else begin
            e.state = 4'd8; e.iord = 1'b1; e.memwrite = 1'b1;
          end
        end
        6'b000000: begin
          e.alucontrol = funct_alu(f);
          if (k == 5) begin
            e.state = 4'd9; e.alusrca = 1'b1;
          end else begin
            e.state = 4'd10; e.regwrite = 1'b1; e.regdst = 1'b1;
          end
        end
        6'b000100: begin
          e.state = 4'd11; e.alusrca = 1'b1; e.alucontrol = 3'b110;
          e.pcsource = 2'b01; e.pcen = z;
        end
        6'b000010: begin
          e.state = 4'd12; e.pcsource = 2'b10; e.pcen = 1'b1;
        end
        6'b001000: begin
          if (k == 5) begin
            e.state = 4'd13; e.alusrca = 1'b1; e.alusrcb = 2'b10;
          end else begin
            e.state = 4'd14; e.regwrite = 1'b1;
          end
        end
        default: e.state = 4'd0;
      endcase
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Entered just after a falling edge with the DUT in FETCH1; leaves it the same way
  task automatic applyStimulus(input string name, input logic [5:0] iop,
                               input logic [5:0] ifunct, input logic [1:0] zmode,
                               input int lat, output logic [31:0] trace);
    out_t exp;
    trace = '0;
    for (int k = 0; k < lat; k++) begin
      if (k < 4) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        op    = iop;
        funct = ifunct;
      end
      zero = (zmode == 2'd2) ? 1'($urandom) : zmode[0];
      #1;
      exp = expect_step(iop, ifunct, zero, k);
      checkOutput($sformatf("%s step%0d", name, k), 32'(actual()), 32'(exp));
      if (k < 8) trace[4*k +: 4] = state;
      @(negedge clk);
    end
    checkOutput({name, " return"}, 32'(state), 32'd0);
  endtask

  vec_t        vecs[13];
  logic [31:0] tr;
  logic [5:0]  legal_ops[6];
  logic [5:0]  legal_functs[5];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{"sub",      6'b000000, 6'b100010, 2'd2, 7, 32'h0A943210};
    vecs[1]  = '{"slt",      6'b000000, 6'b101010, 2'd2, 7, 32'h0A943210};
    vecs[2]  = '{"badfunct", 6'b000000, 6'b000111, 2'd2, 7, 32'h0A943210};
    vecs[3]  = '{"add",      6'b000000, 6'b100000, 2'd0, 7, 32'h0A943210};
    vecs[4]  = '{"and",      6'b000000, 6'b100100, 2'd1, 7, 32'h0A943210};
    vecs[5]  = '{"or",       6'b000000, 6'b100101, 2'd2, 7, 32'h0A943210};
    vecs[6]  = '{"beq_z1",   6'b000100, 6'b000000, 2'd1, 6, 32'h00B43210};
    vecs[7]  = '{"beq_z0",   6'b000100, 6'b111111, 2'd0, 6, 32'h00B43210};
    vecs[8]  = '{"lb",       6'b100000, 6'b000000, 2'd2, 8, 32'h76543210};
    vecs[9]  = '{"sb",       6'b101000, 6'b000000, 2'd2, 7, 32'h08543210};
    vecs[10] = '{"addi",     6'b001000, 6'b101010, 2'd2, 7, 32'h0ED43210};
    vecs[11] = '{"j",        6'b000010, 6'b100010, 2'd2, 6, 32'h00C43210};
    vecs[12] = '{"illegal",  6'b111111, 6'b100000, 2'd2, 5, 32'h00043210};
    legal_ops    = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    legal_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset_n = 1'b0;
    op      = 6'b111111;
    funct   = 6'b100010;
    zero    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset outputs", 32'(actual()), 32'(expect_step(6'b111111, 6'b100010, 1'b1, 0)));
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zmode,
                    vecs[i].lat, tr);
      checkOutput({vecs[i].name, " trace"}, tr, vecs[i].trace);
    end

    // sb abandoned by reset during MEMADR: no SBWR, no memwrite afterwards
    for (int k = 0; k < 6; k++) begin
      op    = (k < 4) ? 6'($urandom) : 6'b101000;
      funct = 6'($urandom);
      zero  = 1'($urandom);
      if (k == 5) reset_n = 1'b0;
      #1;
      checkOutput($sformatf("abort step%0d", k), 32'(actual()),
                  32'(expect_step(6'b101000, funct, zero, k)));
      @(negedge clk);
    end
    #1;
    checkOutput("abort state", 32'(state), 32'd0);
    checkOutput("abort memwrite", 32'(memwrite), 32'd0);
    checkOutput("abort outputs", 32'(actual()), 32'(expect_step(6'b101000, funct, zero, 0)));
    reset_n = 1'b1;
    applyStimulus("after_abort", 6'b000000, 6'b100100, 2'd2, 7, tr);
    checkOutput("after_abort trace", tr, 32'h0A943210);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] rop;
      logic [5:0] rfn;
      int sel;
      sel = int'($urandom_range(0, 7));
      rop = (sel < 6) ? legal_ops[sel] : 6'($urandom);
      rfn = ($urandom_range(0, 1) == 0) ? legal_functs[$urandom_range(0, 4)] : 6'($urandom);
      applyStimulus($sformatf("rand%0d op=%b funct=%b", n, rop, rfn), rop, rfn,
                    2'd2, latency(rop), tr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
